// File: rtl/cache_dm_refill.sv
// cache_dm_refill: direct-mapped, write-through, no-write-allocate data cache
// with an integrated line-refill state machine and saturating hit/miss counters.
//
// Ports:
//   clk, rst               clock and asynchronous active-high reset
//   addr, wdata            CPU byte address and store data
//   MemRead, MemWrite      CPU load / store requests (store has priority)
//   rdata                  registered load data (one cycle after a read hit)
//   hit                    combinational: addressed line valid and tag matches
//   IsStall                combinational: CPU must hold its request
//   mem_req, mem_we        registered memory request and direction (1 = write)
//   mem_addr, mem_wdata    word-aligned memory address and write data
//   mem_rdata, mem_ack     memory read data and one-cycle completion strobe
//   hit_count, miss_count  saturating read-hit / read-miss statistics
module cache_dm_refill #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINES  = 4,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [DATA_W-1:0] rdata,
    output logic              hit,
    output logic              IsStall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned OB    = $clog2(WORDS);
    localparam int unsigned IB    = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - OB - IB - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Address decode of the live CPU address
    logic [OB-1:0]    offset;
    logic [IB-1:0]    index;
    logic [TAG_W-1:0] tag;

    assign offset = addr[OB+1:2];
    assign index  = addr[OB+IB+1:OB+2];
    assign tag    = addr[ADDR_W-1:OB+IB+2];

    // Byte offset never reaches the cache or the word-wide memory port
    logic unused_byte_bits;
    assign unused_byte_bits = ^addr[1:0];

    // Line storage
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][WORDS];

    // Refill context, latched at the miss so CPU address changes are ignored
    logic [TAG_W-1:0] ref_tag_q;
    logic [IB-1:0]    ref_index_q;
    logic [OB-1:0]    cnt_q;
    logic [OB-1:0]    cnt_next;

    assign cnt_next = cnt_q + OB'(1);

    // FSM strobes
    logic stall;
    logic wr_start;
    logic wr_done;
    logic rd_hit;
    logic rd_miss;
    logic ref_ack;
    logic ref_last;
    logic acked;

    assign hit     = valid_q[index] && (tag_q[index] == tag);
    assign IsStall = stall;
    // An ack only counts while a request is outstanding
    assign acked   = mem_ack && mem_req;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        wr_start = 1'b0;
        wr_done  = 1'b0;
        rd_hit   = 1'b0;
        rd_miss  = 1'b0;
        ref_ack  = 1'b0;
        ref_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    wr_start = 1'b1;
                    stall    = 1'b1;
                    state_d  = WRITE;
                end else if (MemRead) begin
                    if (hit) begin
                        rd_hit = 1'b1;
                    end else begin
                        rd_miss = 1'b1;
                        stall   = 1'b1;
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                stall = 1'b1;
                if (acked) begin
                    ref_ack = 1'b1;
                    if (cnt_q == OB'(WORDS - 1)) begin
                        ref_last = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            WRITE: begin
                stall = 1'b1;
                if (acked) begin
                    wr_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control datapath: valid bits, memory port, refill context, statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            rdata       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cnt_q       <= '0;
            ref_tag_q   <= '0;
            ref_index_q <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            if (wr_start) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= wdata;
            end
            if (wr_done) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            if (rd_hit) begin
                rdata <= data_q[index][offset];
                if (hit_count != '1) begin
                    hit_count <= hit_count + CNT_W'(1);
                end
            end
            if (rd_miss) begin
                ref_tag_q      <= tag;
                ref_index_q    <= index;
                valid_q[index] <= 1'b0;
                cnt_q          <= '0;
                mem_req        <= 1'b1;
                mem_we         <= 1'b0;
                mem_addr       <= {tag, index, {OB{1'b0}}, 2'b00};
                if (miss_count != '1) begin
                    miss_count <= miss_count + CNT_W'(1);
                end
            end
            if (ref_ack) begin
                cnt_q    <= cnt_next;
                mem_addr <= {ref_tag_q, ref_index_q, cnt_next, 2'b00};
                if (ref_last) begin
                    valid_q[ref_index_q] <= 1'b1;
                    mem_req              <= 1'b0;
                end
            end
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (wr_start && hit) begin
            data_q[index][offset] <= wdata;
        end
        if (ref_ack) begin
            data_q[ref_index_q][cnt_q] <= mem_rdata;
        end
        if (ref_last) begin
            tag_q[ref_index_q] <= ref_tag_q;
        end
    end

endmodule

// File: tb/tb_cache_dm_refill.sv
// tb_cache_dm_refill: directed bench for cache_dm_refill. A default build and a
// CNT_W=2 build run in lockstep on the same stimulus and memory responses.
// Memory model: read data = 0x90 + word address, ack after ack_delay cycles.
module tb_cache_dm_refill;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic [31:0] rdata;
    logic        hit;
    logic        IsStall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    logic [31:0] s_rdata;
    logic        s_hit;
    logic        s_IsStall;
    logic        s_mem_req;
    logic        s_mem_we;
    logic [31:0] s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [1:0]  s_hit_count;
    logic [1:0]  s_miss_count;

    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic        spur_ack  = 1'b0;
    logic [31:0] rq[$];
    logic [63:0] wq[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cache_dm_refill dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .rdata(rdata), .hit(hit),
        .IsStall(IsStall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_dm_refill #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .rdata(s_rdata), .hit(s_hit),
        .IsStall(s_IsStall), .mem_req(s_mem_req), .mem_we(s_mem_we),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    // Memory responder
    always_comb begin
        mem_ack   = spur_ack | (mem_req & (wait_cnt >= ack_delay));
        mem_rdata = 32'h90 + (mem_addr >> 2);
    end

    // Request age counter and transaction log
    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (!rst && mem_req && mem_ack) begin
            if (mem_we) wq.push_back({mem_addr, mem_wdata});
            else rq.push_back(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    // Issue a read that misses; returns initial hit and number of stall cycles
    task automatic do_miss(input logic [31:0] a, output logic fh, output int n);
        next_cyc();
        addr    = a;
        MemRead = 1'b1;
        #1;
        fh = hit;
        n  = 0;
        while (IsStall && n < 30) begin
            n++;
            next_cyc();
        end
    endtask

    task automatic do_hit(input string tag, input logic [31:0] a, input logic [31:0] exp);
        next_cyc();
        addr    = a;
        MemRead = 1'b1;
        #1;
        check({tag, " hit"}, 64'(hit), 64'd1);
        check({tag, " no stall"}, 64'(IsStall), 64'd0);
        next_cyc();
        MemRead = 1'b0;
        check({tag, " rdata"}, 64'(rdata), 64'(exp));
        check({tag, " no req"}, 64'(mem_req), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic fh;
        int   n;

        rst = 1'b1; addr = '0; wdata = '0; MemRead = 1'b0; MemWrite = 1'b0;
        repeat (2) next_cyc();
        check("reset rdata", 64'(rdata), 64'd0);
        check("reset mem_req", 64'(mem_req), 64'd0);
        check("reset hit_count", 64'(hit_count), 64'd0);
        check("reset miss_count", 64'(miss_count), 64'd0);
        check("reset stall", 64'(IsStall), 64'd0);
        next_cyc();
        rst = 1'b0;

        // Cold read miss on 0x40, immediate acks
        rq.delete();
        do_miss(32'h40, fh, n);
        check("A first hit", 64'(fh), 64'd0);
        check("A stall cycles", 64'(n), 64'd5);
        check("A hit after refill", 64'(hit), 64'd1);
        check("A refill count", 64'(rq.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check("A refill addr", 64'((rq.size() > i) ? rq[i] : 32'hFFFF_FFFF), 64'(32'h40 + 4 * i));
        next_cyc();
        MemRead = 1'b0;
        check("A rdata", 64'(rdata), 64'hA0);
        check("A hit_count", 64'(hit_count), 64'd1);
        check("A miss_count", 64'(miss_count), 64'd1);

        do_hit("B", 32'h48, 32'hA2);

        // Stray ack with no request outstanding
        next_cyc();
        spur_ack = 1'b1;
        next_cyc();
        spur_ack = 1'b0;
        check("spur mem_req", 64'(mem_req), 64'd0);
        check("spur stall", 64'(IsStall), 64'd0);
        check("spur no write", 64'(wq.size()), 64'd0);
        do_hit("spur", 32'h4C, 32'hA3);

        // Write hit with ack delayed 3 cycles
        ack_delay = 3;
        next_cyc();
        addr = 32'h44; wdata = 32'hDEAD_BEEF; MemWrite = 1'b1;
        #1;
        check("C stall", 64'(IsStall), 64'd1);
        next_cyc();
        MemWrite = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        check("C mem_we", 64'(mem_we), 64'd1);
        check("C mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        n = 0;
        while (mem_req && n < 20) begin
            check("C addr stable", 64'(mem_addr), 64'h44);
            n++;
            next_cyc();
        end
        check("C req cycles", 64'(n), 64'd4);
        check("C stall released", 64'(IsStall), 64'd0);
        check("C write logged", 64'((wq.size() == 1) ? wq[0] : 64'h0), {32'h44, 32'hDEAD_BEEF});
        ack_delay = 0;
        do_hit("C read", 32'h44, 32'hDEAD_BEEF);

        // Write miss does not allocate
        next_cyc();
        addr = 32'h80; wdata = 32'h1234_5678; MemWrite = 1'b1;
        next_cyc();
        MemWrite = 1'b0;
        check("D mem_addr", 64'(mem_addr), 64'h80);
        check("D mem_we", 64'(mem_we), 64'd1);
        next_cyc();
        check("D req dropped", 64'(mem_req), 64'd0);
        check("D write logged", 64'((wq.size() == 2) ? wq[1] : 64'h0), {32'h80, 32'h1234_5678});
        addr = 32'h80;
        #1;
        check("D no allocate", 64'(hit), 64'd0);
        do_hit("D old line", 32'h40, 32'hA0);

        // Conflict miss replaces the line, then the old address misses
        rq.delete();
        do_miss(32'h80, fh, n);
        check("E stall cycles", 64'(n), 64'd5);
        check("E refill base", 64'((rq.size() > 0) ? rq[0] : 32'h0), 64'h80);
        next_cyc();
        MemRead = 1'b0;
        check("E rdata", 64'(rdata), 64'hB0);
        check("E miss_count", 64'(miss_count), 64'd2);
        do_miss(32'h40, fh, n);
        check("E old addr misses", 64'(fh), 64'd0);
        check("E2 stall cycles", 64'(n), 64'd5);
        next_cyc();
        MemRead = 1'b0;
        check("E2 rdata", 64'(rdata), 64'hA0);
        check("E2 hit_count", 64'(hit_count), 64'd7);
        check("E2 miss_count", 64'(miss_count), 64'd3);
        check("sat hit_count", 64'(s_hit_count), 64'd3);
        check("sat miss_count", 64'(s_miss_count), 64'd3);

        // Reset after 2 of 4 refill acks
        rq.delete();
        next_cyc();
        addr = 32'hC0; MemRead = 1'b1;
        repeat (3) next_cyc();
        rst = 1'b1;
        MemRead = 1'b0;
        #1;
        check("F acks before reset", 64'(rq.size()), 64'd2);
        check("F mem_req", 64'(mem_req), 64'd0);
        check("F mem_we", 64'(mem_we), 64'd0);
        check("F mem_addr", 64'(mem_addr), 64'd0);
        check("F rdata", 64'(rdata), 64'd0);
        check("F hit_count", 64'(hit_count), 64'd0);
        check("F miss_count", 64'(miss_count), 64'd0);
        next_cyc();
        rst = 1'b0;
        rq.delete();
        do_miss(32'hC0, fh, n);
        check("F re-read misses", 64'(fh), 64'd0);
        check("F stall cycles", 64'(n), 64'd5);
        check("F full refill", 64'(rq.size()), 64'd4);
        check("F last word addr", 64'((rq.size() == 4) ? rq[3] : 32'h0), 64'hCC);

        // Six consecutive read hits: narrow counter saturates at 3
        repeat (6) next_cyc();
        MemRead = 1'b0;
        check("G rdata", 64'(rdata), 64'hC0);
        check("G hit_count", 64'(hit_count), 64'd6);
        check("G sat hit_count", 64'(s_hit_count), 64'd3);
        check("G miss_count", 64'(miss_count), 64'd1);
        check("G sat miss_count", 64'(s_miss_count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_dm_refill.md
Name: cache_dm_refill

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache with an integrated refill state machine.
- Sits between the CPU datapath (MemRead/MemWrite, stall) and a word-wide memory port with a req/ack handshake.
- Replaces the externally counter-driven refill scheme: line count, words per line and address width are generic.
- Adds registered memory requests, write-through forwarding and saturating hit/miss statistics.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width (byte offset fixed at 2 bits)
LINES, 4, number of cache lines, power of two, >=2
WORDS, 4, words per line, power of two, >=2
CNT_W, 16, width of hit/miss statistic counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
addr  in  ADDR_W  CPU byte address
wdata  in  DATA_W  CPU store data
MemRead  in  1  CPU load request
MemWrite  in  1  CPU store request
rdata  out  DATA_W  load data, registered
hit  out  1  combinational: valid[index] & tag match for current addr
IsStall  out  1  CPU must hold request and addr/wdata
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  word-aligned memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle completion strobe
hit_count  out  CNT_W  saturating count of read hits
miss_count  out  CNT_W  saturating count of read misses

Behaviour:
- Address split: offset = addr[OB+1:2], OB = log2(WORDS); index = next log2(LINES) bits; tag = remaining upper bits.
- Storage: per line a valid bit, a tag and WORDS data words.
- Reset (async): all valid cleared, state IDLE, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, refill counter=0, hit_count=0, miss_count=0.
- States: IDLE, REFILL, WRITE.
- IDLE, MemWrite=1 (priority over MemRead if both high):
  - if hit, the addressed word is updated at the edge;
  - latch addr/wdata into mem_addr/mem_wdata, mem_req<=1, mem_we<=1, go WRITE;
  - a write miss does not allocate.
- IDLE, MemRead=1, hit: rdata <= addressed word at the edge (1-cycle latency); hit_count++.
- IDLE, MemRead=1, miss:
  - latch tag/index, valid[index]<=0, counter<=0, miss_count++;
  - mem_req<=1, mem_we<=0, mem_addr<={tag,index,0,2'b00}; go REFILL.
- REFILL, each cycle with mem_ack=1:
  - word[counter] <= mem_rdata, counter++;
  - mem_addr advances to the next word; mem_req stays high.
- REFILL, ack of word WORDS-1:
  - tag stored, valid<=1, mem_req<=0, go IDLE;
  - the held MemRead then hits on the following cycle and counts as a hit.
- WRITE: on mem_ack, mem_req<=0, mem_we<=0, go IDLE.
- Handshake:
  - mem_req/mem_addr/mem_we/mem_wdata stay stable until acked;
  - mem_ack while mem_req=0 is ignored;
  - ack may arrive in the first cycle after req rises; one word per ack.
- Stall: IsStall = (state!=IDLE) | (state==IDLE & MemWrite) | (state==IDLE & MemRead & !hit).
  - A write therefore stalls until its ack.
  - A read miss stalls WORDS acks plus the return cycle.
- addr/wdata changes during REFILL or WRITE are ignored; latched values are used.
- Counters saturate at all-ones and never wrap.
- Reset mid-REFILL aborts the refill: the line stays invalid and mem_req drops immediately.
- Neither MemRead nor MemWrite in IDLE: no state change, rdata holds.

Test Plan:
- Reset, then MemRead addr=0x40 (index0, tag1), memory returns 0xA0..0xA3 with immediate acks:
  - mem_addr steps 0x40,0x44,0x48,0x4C;
  - IsStall high 5 cycles, then hit=1 and rdata=0xA0;
  - miss_count=1, hit_count=1.
- After the refill, MemRead 0x48: hit=1, IsStall=0, rdata=0xA2 next cycle, no mem_req.
- MemWrite 0x44 wdata=0xDEADBEEF on the resident line:
  - mem_req/mem_we=1, mem_addr=0x44 until an ack delayed 3 cycles;
  - a following read of 0x44 hits and returns 0xDEADBEEF.
- MemWrite 0x80 (index0, tag2, miss): memory write issued; the line still holds tag1, and a read of 0x40 still hits.
- Conflict read 0x80 after the line is loaded: valid cleared at the miss and refill from 0x80; a subsequent read of 0x40 misses.
- Assert rst after 2 of 4 acks during a refill:
  - all outputs return to reset values, mem_req=0;
  - a re-read of the same address misses and performs a full 4-word refill.
- CNT_W=2 build, 5 read hits: hit_count saturates at 3.
